ipm2l_fifo_wr_arb: RTL
======================

// Module: ipm2l_fifo_wr_arb
// PURPOSE
//  Round-robin write arbiter sharing one synchronous FIFO write port between c_NUM_REQ requesters.
//  Grants one requester at a time, locks the grant for a burst of up to c_BURST_LEN beats, then rotates.
//  Throttles burst starts on almost_full and stalls beats on wr_full.
//  Sits between the requester valid/ready interfaces and the FIFO write side (wr_en/wr_data/wr_full/almost_full).
// PARAMETERS
//  c_NUM_REQ     4   number of requesters, 2..8
//  c_DATA_WIDTH  32  beat width; equals the FIFO c_WR_DATA_WIDTH
//  c_BURST_LEN   8   maximum beats per grant, 1..256
//  c_ID_WIDTH    2   grant id width; must satisfy 2**c_ID_WIDTH >= c_NUM_REQ
//  c_AF_THROTTLE 1   1: a new burst does not start while fifo_almost_full=1; 0: ignore almost_full
// PORTS
//  clk               in   1                       single clock, shared with the FIFO wr_clk and rd_clk (SYN FIFO)
//  rst_n             in   1                       synchronous reset, active-low
//  req_valid         in   c_NUM_REQ               per-requester beat valid
//  req_data          in   c_NUM_REQ*c_DATA_WIDTH  requester i occupies bits [i*W +: W]
//  req_last          in   c_NUM_REQ               final beat of a packet; ends the burst early
//  req_ready         out  c_NUM_REQ               beat accepted when valid & ready
//  fifo_wr_en        out  1                       to FIFO wr_en
//  fifo_wr_data      out  c_DATA_WIDTH            to FIFO wr_data
//  fifo_wr_full      in   1                       from FIFO wr_full
//  fifo_almost_full  in   1                       from FIFO almost_full
//  grant_id          out  c_ID_WIDTH              index of the current or last granted requester
//  busy              out  1                       1 while in BURST
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge) sets the FSM to IDLE, rr_ptr=0, beat_cnt=0, grant_id=0 and busy=0.
//   req_ready and fifo_wr_en are 0 while in IDLE.
//   Reset mid-burst abandons the burst immediately; beats not yet accepted are not written.
//  FSM states: IDLE, BURST.
//  IDLE:
//   - start = |req_valid & ~fifo_wr_full & ~(c_AF_THROTTLE & fifo_almost_full).
//   - On start, grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo c_NUM_REQ.
//   - Registers grant_id=i and beat_cnt=0, then moves to BURST.
//   - No beat is transferred in IDLE.
//  BURST (g = grant_id):
//   - req_ready[g] = ~fifo_wr_full; all other req_ready bits are 0. req_ready is combinational.
//   - fifo_wr_en = req_valid[g] & ~fifo_wr_full, combinational.
//   - fifo_wr_data = req_data[g], combinational pass-through; it is don't-care when fifo_wr_en=0.
//   - A beat occurs when fifo_wr_en=1; each beat increments beat_cnt.
//   - fifo_almost_full is ignored inside a burst; only fifo_wr_full stalls.
//   - A burst ends on a beat with req_last[g]=1 or with beat_cnt==c_BURST_LEN-1.
//     On that beat: next state IDLE, rr_ptr = (g+1) mod c_NUM_REQ, beat_cnt=0.
//   - req_valid[g] low mid-burst keeps the grant; the arbiter waits (no timeout).
//  Latency: a valid in IDLE at edge t gives a grant after edge t; the first write is in cycle t+1 if not full.
//   There is exactly one idle cycle between consecutive bursts.
//  Rotation: a requester just served has the lowest priority at the next arbitration.
//   Every continuously-valid requester is granted within c_NUM_REQ arbitrations.
//  Wrap-around: rr_ptr wraps from c_NUM_REQ-1 to 0.
//   beat_cnt never exceeds c_BURST_LEN-1; it is 8 bits wide.
//  Simultaneous events:
//   - fifo_wr_full rising in the same cycle as the final beat: no beat occurs, and the burst stays open until full clears.
//   - req_last on the c_BURST_LEN-th beat ends the burst once (no double rotation).
//  Data integrity: no beat is ever written while fifo_wr_full=1, and no accepted beat is dropped.
// TESTING
//  1. Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, fifo_wr_en=0, busy=0, grant_id=0.
//  2. Single requester: req 2 sends 3 beats (0xA0..0xA2) with last on the third
//     -> 3 FIFO writes in order, then IDLE, rr_ptr=3.
//  3. Round robin: all 4 valid, no last, c_BURST_LEN=8 -> grants 0,1,2,3,0.
//     Each burst is 8 writes; exactly 1 idle cycle between bursts.
//  4. Full stall: assert fifo_wr_full for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 for those 5 cycles.
//     The burst resumes with no lost or duplicated beat.
//  5. Almost-full throttle: fifo_almost_full=1 in IDLE with req 1 valid -> no grant until it drops.
//     Asserting it mid-burst leaves the burst running.
//  6. Reset mid-burst: drop rst_n after beat 4 of 8 -> next cycle IDLE, fifo_wr_en=0, rr_ptr=0.
//     Scoreboard: total FIFO writes equal accepted beats, with each requester's beats kept in its own order.

Source files
------------

// File: rtl/ipm2l_fifo_wr_arb.sv
// Round-robin write arbiter: shares one sync FIFO write port
// between requesters, burst-locked grants with rotation.
module ipm2l_fifo_wr_arb #(
  parameter int c_NUM_REQ     = 4,
  parameter int c_DATA_WIDTH  = 32,
  parameter int c_BURST_LEN   = 8,
  parameter int c_ID_WIDTH    = 2,
  parameter int c_AF_THROTTLE = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [c_NUM_REQ-1:0]              req_valid,
  input  logic [c_NUM_REQ*c_DATA_WIDTH-1:0] req_data,
  input  logic [c_NUM_REQ-1:0]              req_last,
  output logic [c_NUM_REQ-1:0]              req_ready,
  output logic                              fifo_wr_en,
  output logic [c_DATA_WIDTH-1:0]           fifo_wr_data,
  input  logic                              fifo_wr_full,
  input  logic                              fifo_almost_full,
  output logic [c_ID_WIDTH-1:0]             grant_id,
  output logic                              busy
);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  localparam logic [7:0] LastCnt = 8'(c_BURST_LEN - 1);
  localparam logic [c_ID_WIDTH-1:0] LastId =
    c_ID_WIDTH'(c_NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [c_ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [c_ID_WIDTH-1:0]   grant_q, grant_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;

  logic                    g_valid;
  logic                    g_last;
  logic [c_DATA_WIDTH-1:0] g_data;
  logic                    pick_found;
  logic [c_ID_WIDTH-1:0]   pick;
  int                      idx;
  logic                    af_block;
  logic                    start;
  logic                    beat;
  logic                    burst_end;

  // Select the granted requester's lane.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < c_NUM_REQ; i++) begin
      if (grant_q == c_ID_WIDTH'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*c_DATA_WIDTH +: c_DATA_WIDTH];
      end
    end
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int k = 0; k < c_NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % c_NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick       = c_ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    af_block  = (c_AF_THROTTLE != 0) && fifo_almost_full;
    start     = (|req_valid) && !fifo_wr_full && !af_block;
    beat      = (state_q == BURST) && g_valid && !fifo_wr_full;
    burst_end = beat && (g_last || (beat_cnt_q == LastCnt));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BURST;
      BURST:   if (burst_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE && start) begin
      grant_d    = pick;
      beat_cnt_d = '0;
    end else if (burst_end) begin
      beat_cnt_d = '0;
      rr_ptr_d   = (grant_q == LastId) ? '0 : grant_q + 1'b1;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = g_data;
    busy         = (state_q == BURST);
    grant_id     = grant_q;
    if (state_q == BURST) begin
      for (int i = 0; i < c_NUM_REQ; i++) begin
        if (grant_q == c_ID_WIDTH'(i)) begin
          req_ready[i] = !fifo_wr_full;
        end
      end
      fifo_wr_en = g_valid && !fifo_wr_full;
    end
  end

endmodule
